// File: rtl/blu_defs_pkg.sv
// Shared definitions for the bitwise logic unit: opcode encodings and FSM states.
// Optional feature macro: BLU_FLAGS_EN (adds flag_zero / flag_ones outputs).
package blu_defs_pkg;

    localparam logic [2:0] BLU_AND  = 3'b000;
    localparam logic [2:0] BLU_OR   = 3'b001;
    localparam logic [2:0] BLU_XOR  = 3'b010;
    localparam logic [2:0] BLU_NAND = 3'b011;
    localparam logic [2:0] BLU_NOR  = 3'b100;
    localparam logic [2:0] BLU_XNOR = 3'b101;
    localparam logic [2:0] BLU_ANDN = 3'b110;
    localparam logic [2:0] BLU_NOTA = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } blu_state_t;

endpackage

// File: rtl/bitwise_logic_unit_slice.sv
// Combinational CHUNK-bit datapath: applies one of the eight bitwise ops to a slice.
module blu_slice
    import blu_defs_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic [2:0]       op,
    output logic [CHUNK-1:0] y
);

    // Select the bitwise function for the current slice
    always_comb begin
        y = {CHUNK{1'b0}};
        case (op)
            BLU_AND:  y = a & b;
            BLU_OR:   y = a | b;
            BLU_XOR:  y = a ^ b;
            BLU_NAND: y = ~(a & b);
            BLU_NOR:  y = ~(a | b);
            BLU_XNOR: y = ~(a ^ b);
            BLU_ANDN: y = a & ~b;
            BLU_NOTA: y = ~a;
            default:  y = {CHUNK{1'b0}};
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: latches operands on start, computes CHUNK bits
// per RUN cycle, then pulses data_resultRDY for one cycle in DONE.
// Optional feature macro: BLU_FLAGS_EN adds flag_zero / flag_ones result flags.
module bitwise_logic_unit
    import blu_defs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_start,
    input  logic [2:0]       ctrl_op,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    output logic             busy,
    output logic             data_resultRDY,
`ifdef BLU_FLAGS_EN
    output logic             flag_zero,
    output logic             flag_ones,
`endif
    output logic [WIDTH-1:0] data_result
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    // Trap operand widths that do not split into whole slices
    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("bitwise_logic_unit: WIDTH must be a multiple of CHUNK");
    end

    blu_state_t       state_r;
    logic [IDXW-1:0]  idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] result_r;
    logic             busy_r;
    logic             rdy_r;
    logic [CHUNK-1:0] a_slice_s;
    logic [CHUNK-1:0] b_slice_s;
    logic [CHUNK-1:0] y_slice_s;
    logic             accept_s;
`ifdef BLU_FLAGS_EN
    logic             flag_zero_r;
    logic             flag_ones_r;
`endif

    // A new request is only taken when no operation is in flight
    always_comb begin
        accept_s = ctrl_start && ((state_r == IDLE) || (state_r == DONE));
    end

    // Feed the single slice datapath from the latched operands at the current index
    always_comb begin
        a_slice_s = a_r[idx_r * CHUNK +: CHUNK];
        b_slice_s = b_r[idx_r * CHUNK +: CHUNK];
    end

    blu_slice #(.CHUNK(CHUNK)) u_slice (
        .a  (a_slice_s),
        .b  (b_slice_s),
        .op (op_r),
        .y  (y_slice_s)
    );

    // FSM, operand latches, slice index and result register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            idx_r       <= {IDXW{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            op_r        <= 3'b000;
            result_r    <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            rdy_r       <= 1'b0;
`ifdef BLU_FLAGS_EN
            flag_zero_r <= 1'b0;
            flag_ones_r <= 1'b0;
`endif
        end else if (accept_s) begin
            // Operands are captured here so later input changes cannot disturb the run
            state_r     <= RUN;
            idx_r       <= {IDXW{1'b0}};
            a_r         <= data_A;
            b_r         <= data_B;
            op_r        <= ctrl_op;
            busy_r      <= 1'b1;
            rdy_r       <= 1'b0;
`ifdef BLU_FLAGS_EN
            flag_zero_r <= 1'b1;
            flag_ones_r <= 1'b1;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                    rdy_r  <= 1'b0;
                end
                RUN: begin
                    result_r[idx_r * CHUNK +: CHUNK] <= y_slice_s;
`ifdef BLU_FLAGS_EN
                    flag_zero_r <= flag_zero_r & (y_slice_s == {CHUNK{1'b0}});
                    flag_ones_r <= flag_ones_r & (&y_slice_s);
`endif
                    if (idx_r == IDX_LAST) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        rdy_r   <= 1'b1;
                    end else begin
                        idx_r   <= idx_r + IDXW'(1);
                        busy_r  <= 1'b1;
                        rdy_r   <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    rdy_r   <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    rdy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_r;
    assign data_resultRDY = rdy_r;
    assign data_result    = result_r;
`ifdef BLU_FLAGS_EN
    assign flag_zero      = flag_zero_r;
    assign flag_ones      = flag_ones_r;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: table of opcode vectors driven through
// a result scoreboard, plus hand-written sequences for the multi-cycle corner cases.
module tb_bitwise_logic_unit;

    logic        clock;
    logic        resetn;
    logic        ctrl_start;
    logic [2:0]  ctrl_op;
    logic [31:0] data_A;
    logic [31:0] data_B;
    logic        busy;
    logic        data_resultRDY;
    logic [31:0] data_result;

    logic        s_start;
    logic [2:0]  s_op;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic        s_busy;
    logic        s_rdy;
    logic [31:0] s_result;
`ifdef BLU_FLAGS_EN
    logic        flag_zero;
    logic        flag_ones;
    logic        s_flag_zero;
    logic        s_flag_ones;
`endif

    bitwise_logic_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_start     (ctrl_start),
        .ctrl_op        (ctrl_op),
        .data_A         (data_A),
        .data_B         (data_B),
        .busy           (busy),
        .data_resultRDY (data_resultRDY),
`ifdef BLU_FLAGS_EN
        .flag_zero      (flag_zero),
        .flag_ones      (flag_ones),
`endif
        .data_result    (data_result)
    );

    bitwise_logic_unit #(.WIDTH(32), .CHUNK(32)) dut_single (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_start     (s_start),
        .ctrl_op        (s_op),
        .data_A         (s_a),
        .data_B         (s_b),
        .busy           (s_busy),
        .data_resultRDY (s_rdy),
`ifdef BLU_FLAGS_EN
        .flag_zero      (s_flag_zero),
        .flag_ones      (s_flag_ones),
`endif
        .data_result    (s_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    vec_t  vecs[11];
    exp_t  sbq[$];
    int    total;
    int    bad;
    int    cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock, sample #1 after the edge and retire any completed result
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        if (data_resultRDY) begin
            if (sbq.size() == 0) begin
                check("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("result", data_result, e.res);
                check("rdy_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    // Drive an accepted request (caller guarantees IDLE or DONE) and queue its expectation
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        exp_t e;
        ctrl_op    = op;
        data_A     = a;
        data_B     = b;
        ctrl_start = 1'b1;
        e.res      = exp;
        e.cyc      = cyc + 5;
        sbq.push_back(e);
        tick();
        ctrl_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            check("rdy_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        resetn = 1'b0;
        ctrl_start = 1'b0; ctrl_op = 3'b000; data_A = 32'h0; data_B = 32'h0;
        s_start = 1'b0; s_op = 3'b000; s_a = 32'h0; s_b = 32'h0;

        vecs[0]  = '{3'b000, 32'h0000_FFFF, 32'h00FF_00FF, 32'h0000_00FF};
        vecs[1]  = '{3'b001, 32'h0000_FFFF, 32'h00FF_00FF, 32'h00FF_FFFF};
        vecs[2]  = '{3'b010, 32'h0000_FFFF, 32'h00FF_00FF, 32'h00FF_FF00};
        vecs[3]  = '{3'b011, 32'h0000_FFFF, 32'h00FF_00FF, 32'hFFFF_FF00};
        vecs[4]  = '{3'b100, 32'h0000_FFFF, 32'h00FF_00FF, 32'hFF00_0000};
        vecs[5]  = '{3'b101, 32'h0000_FFFF, 32'h00FF_00FF, 32'hFF00_00FF};
        vecs[6]  = '{3'b110, 32'h0000_FFFF, 32'h00FF_00FF, 32'h0000_FF00};
        vecs[7]  = '{3'b111, 32'h0000_FFFF, 32'h00FF_00FF, 32'hFFFF_0000};
        vecs[8]  = '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[9]  = '{3'b001, 32'h1234_5678, 32'h8765_4321, 32'h9775_5779};
        vecs[10] = '{3'b010, 32'h1234_5678, 32'h8765_4321, 32'h9551_1559};

        // Reset state
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rdy", 32'(data_resultRDY), 32'd0);
        check("reset_result", data_result, 32'h0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Opcode table through the scoreboard
        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            wait_idle();
            tick();
        end

        // Busy high in cycles 1..4, RDY only in cycle 5
        start_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        check("busy_c1", 32'(busy), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("busy_run", 32'(busy), (k <= 4) ? 32'd1 : 32'd0);
            check("rdy_pulse", 32'(data_resultRDY), (k == 5) ? 32'd1 : 32'd0);
        end
        tick();
        check("rdy_one_cycle", 32'(data_resultRDY), 32'd0);
        wait_idle();

        // Start during RUN is ignored; inputs changing after accept do not matter
        start_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        tick();
        ctrl_op = 3'b001; data_A = 32'hFFFF_FFFF; data_B = 32'hFFFF_FFFF; ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        wait_idle();
        tick();
        check("ignored_no_restart", 32'(busy), 32'd0);

        // Back-to-back: second start lands in the DONE cycle of the first
        start_op(3'b011, 32'h0000_FFFF, 32'h00FF_00FF, 32'hFFFF_FF00);
        for (int k = 0; k < 4; k++) tick();
        check("b2b_first_rdy_seen", 32'(sbq.size()), 32'd0);
        start_op(3'b010, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_idle();
        tick();

        // Reset in the middle of RUN aborts without a RDY pulse
        start_op(3'b001, 32'h0F0F_0F0F, 32'h0000_0000, 32'h0F0F_0F0F);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", data_result, 32'h0);
        check("abort_rdy", 32'(data_resultRDY), 32'd0);
        void'(sbq.pop_back());
        tick();
        resetn = 1'b1;
        tick();
        start_op(3'b000, 32'hFFFF_FFFF, 32'h1357_9BDF, 32'h1357_9BDF);
        wait_idle();
        tick();

        // Single-pass build: CHUNK == WIDTH, latency 2
        s_op = 3'b001; s_a = 32'hFFFF_FFFF; s_b = 32'h0000_0000; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("single_busy", 32'(s_busy), 32'd1);
        tick();
        check("single_or_rdy", 32'(s_rdy), 32'd1);
        check("single_or_result", s_result, 32'hFFFF_FFFF);
`ifdef BLU_FLAGS_EN
        check("single_or_flag_zero", 32'(s_flag_zero), 32'd0);
        check("single_or_flag_ones", 32'(s_flag_ones), 32'd1);
`endif
        tick();
        s_op = 3'b010; s_a = 32'hDEAD_BEEF; s_b = 32'hDEAD_BEEF; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("single_xor_rdy_c1", 32'(s_rdy), 32'd0);
        tick();
        check("single_xor_rdy_c2", 32'(s_rdy), 32'd1);
        check("single_xor_result", s_result, 32'h0);
`ifdef BLU_FLAGS_EN
        check("single_xor_flag_zero", 32'(s_flag_zero), 32'd1);
        check("single_xor_flag_ones", 32'(s_flag_ones), 32'd0);
`endif
        tick();
        check("single_rdy_drop", 32'(s_rdy), 32'd0);

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
